pipe_test_ctrl: RTL and testbench

PIPE_TEST_CTRL -- requirements
Module: pipe_test_ctrl

---
 rtl/pipe_test_ctrl_if.sv | 38 +++
 rtl/pipe_test_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pipe_test_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_test_ctrl_if.sv
// Control/status bundle between pipe_test_ctrl and its environment.
// master: the controller side; slave: the host plus pipe-in checker side.
interface pipe_test_ctrl_if;
    // Every signal here is single-cycle sampled on clk. There is no valid/ready pair:
    // start is a one-cycle request, done is a one-cycle completion pulse and the
    // checker's chk_valid is only monitored, never back-pressured.
    logic        start;
    logic        abort;
    logic        cfg_mode;
    logic [31:0] cfg_throttle;
    logic [31:0] cfg_words;
    logic        chk_reset;
    logic        chk_mode;
    logic        throttle_set;
    logic [31:0] throttle_val;
    logic        chk_valid;
    logic [31:0] chk_error_count;
    logic        busy;
    logic        done;
    logic        pass;
    logic        aborted;
    logic        timed_out;
    logic [31:0] words_seen;
    logic [31:0] result_errors;
    logic [2:0]  state_dbg;

    modport master (
        input  start, abort, cfg_mode, cfg_throttle, cfg_words, chk_valid, chk_error_count,
        output chk_reset, chk_mode, throttle_set, throttle_val, busy, done, pass,
               aborted, timed_out, words_seen, result_errors, state_dbg
    );

    modport slave (
        output start, abort, cfg_mode, cfg_throttle, cfg_words, chk_valid, chk_error_count,
        input  chk_reset, chk_mode, throttle_set, throttle_val, busy, done, pass,
               aborted, timed_out, words_seen, result_errors, state_dbg
    );
endinterface

// File: rtl/pipe_test_ctrl.sv
// Sequences one pipe-in checker test run: reset, throttle load, word counting, drain, report.
// Optional RUN idle timeout is enabled with `define PIPE_TEST_TIMEOUT_EN.
module pipe_test_ctrl #(
    parameter int unsigned RESET_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input logic              clk,
    input logic              reset,
    pipe_test_ctrl_if.master bus
);
    localparam logic [31:0] RESET_LAST = 32'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_LOAD   = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4,
        S_REPORT = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] phase_cnt_q, phase_cnt_d;
    logic        mode_q, mode_d;
    logic [31:0] throttle_q, throttle_d;
    logic [31:0] words_q, words_d;
    logic [31:0] words_seen_q, words_seen_d;
    logic [31:0] result_errors_q, result_errors_d;
    logic        pass_q, pass_d;
    logic        aborted_q, aborted_d;
    logic        done_q, done_d;
    logic        timed_out_cur;
    logic [31:0] words_seen_inc;

`ifdef PIPE_TEST_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);
    logic        timed_out_q, timed_out_d;
    logic [31:0] idle_cnt_q, idle_cnt_d;
    assign timed_out_cur = timed_out_q;
`else
    assign timed_out_cur = 1'b0;
`endif

    assign words_seen_inc = words_seen_q + 32'd1;

    always_comb begin
        state_d         = state_q;
        phase_cnt_d     = phase_cnt_q;
        mode_d          = mode_q;
        throttle_d      = throttle_q;
        words_d         = words_q;
        words_seen_d    = words_seen_q;
        result_errors_d = result_errors_q;
        pass_d          = pass_q;
        aborted_d       = aborted_q;
        done_d          = 1'b0;
`ifdef PIPE_TEST_TIMEOUT_EN
        timed_out_d     = timed_out_q;
        idle_cnt_d      = idle_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d       = bus.cfg_mode;
                    throttle_d   = bus.cfg_throttle;
                    words_d      = bus.cfg_words;
                    words_seen_d = '0;
                    aborted_d    = 1'b0;
                    phase_cnt_d  = '0;
`ifdef PIPE_TEST_TIMEOUT_EN
                    timed_out_d  = 1'b0;
`endif
                    state_d      = S_RESET;
                end
            end
            S_RESET: begin
                if (bus.abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_REPORT;
                end else if (phase_cnt_q == RESET_LAST) begin
                    state_d = S_LOAD;
                end else begin
                    phase_cnt_d = phase_cnt_q + 32'd1;
                end
            end
            S_LOAD: begin
                phase_cnt_d = '0;
`ifdef PIPE_TEST_TIMEOUT_EN
                idle_cnt_d  = '0;
`endif
                if (bus.abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_REPORT;
                end else if (words_q == '0) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // A word arriving alongside abort is still counted.
                if (bus.chk_valid) words_seen_d = words_seen_inc;
`ifdef PIPE_TEST_TIMEOUT_EN
                idle_cnt_d = bus.chk_valid ? '0 : idle_cnt_q + 32'd1;
`endif
                if (bus.abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_REPORT;
                end else if (bus.chk_valid && (words_seen_inc == words_q)) begin
                    phase_cnt_d = '0;
                    state_d     = S_DRAIN;
                end
`ifdef PIPE_TEST_TIMEOUT_EN
                else if (!bus.chk_valid && (idle_cnt_d == TIMEOUT_LIM)) begin
                    timed_out_d = 1'b1;
                    state_d     = S_REPORT;
                end
`endif
            end
            S_DRAIN: begin
                // Two cycles let the checker's registered error count catch up.
                if (bus.abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_REPORT;
                end else if (phase_cnt_q == 32'd1) begin
                    state_d = S_REPORT;
                end else begin
                    phase_cnt_d = phase_cnt_q + 32'd1;
                end
            end
            S_REPORT: begin
                result_errors_d = bus.chk_error_count;
                pass_d = (bus.chk_error_count == '0) && !aborted_q && !timed_out_cur &&
                         (words_seen_q == words_q);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            phase_cnt_q     <= '0;
            mode_q          <= 1'b0;
            throttle_q      <= '0;
            words_q         <= '0;
            words_seen_q    <= '0;
            result_errors_q <= '0;
            pass_q          <= 1'b0;
            aborted_q       <= 1'b0;
            done_q          <= 1'b0;
`ifdef PIPE_TEST_TIMEOUT_EN
            timed_out_q     <= 1'b0;
            idle_cnt_q      <= '0;
`endif
        end else begin
            state_q         <= state_d;
            phase_cnt_q     <= phase_cnt_d;
            mode_q          <= mode_d;
            throttle_q      <= throttle_d;
            words_q         <= words_d;
            words_seen_q    <= words_seen_d;
            result_errors_q <= result_errors_d;
            pass_q          <= pass_d;
            aborted_q       <= aborted_d;
            done_q          <= done_d;
`ifdef PIPE_TEST_TIMEOUT_EN
            timed_out_q     <= timed_out_d;
            idle_cnt_q      <= idle_cnt_d;
`endif
        end
    end

    // done is registered so it rises in the same cycle the new results become visible.
    assign bus.chk_reset     = reset | (state_q == S_RESET);
    assign bus.throttle_set  = (state_q == S_LOAD);
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.chk_mode      = mode_q;
    assign bus.throttle_val  = throttle_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.aborted       = aborted_q;
    assign bus.timed_out     = timed_out_cur;
    assign bus.words_seen    = words_seen_q;
    assign bus.result_errors = result_errors_q;
    assign bus.state_dbg     = state_q;
endmodule

// File: tb/tb_pipe_test_ctrl.sv
// Randomized bench for pipe_test_ctrl, checked against a cycle-schedule model of a test run.
// Define PIPE_TEST_TIMEOUT_EN to exercise the idle timeout.
module tb_pipe_test_ctrl;
    localparam int R    = 4;
    localparam int TO   = 100;
    localparam int MAXC = 1024;
`ifdef PIPE_TEST_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   vpat [0:MAXC-1];

    pipe_test_ctrl_if bus ();

    pipe_test_ctrl #(.RESET_CYCLES(R), .TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic fill_random(input int pct);
        for (int i = 0; i < MAXC; i++) vpat[i] = ($urandom_range(99) < pct);
    endtask

    // One full run. Cycle k is the k-th clock period after the edge that accepts start.
    task automatic scenario(input string name, input logic [31:0] words, input logic [31:0] errs,
                            input logic mode, input logic [31:0] thr, input int ab_at,
                            input int restart_at);
        int t, seen, idle, rc_m, ts_m, rep_t;
        bit ab, to, stop, fin, exp_pass;
        int rc_o, ts_o, busy_o, done_n, done_k;
        bit cfg_bad;
        // Expected schedule: R reset cycles, one load, run until count, two drain, one report.
        t = 1; seen = 0; idle = 0; rc_m = 0; ts_m = 0; ab = 0; to = 0; stop = 0; fin = 0;
        for (int i = 0; i < R && !stop; i++) begin
            rc_m++;
            if (t == ab_at) begin ab = 1; stop = 1; end
            t++;
        end
        if (!stop) begin
            ts_m = 1;
            if (t == ab_at) begin ab = 1; stop = 1; end
            t++;
        end
        if (!stop && words != 0) begin
            while (!stop && !fin && t < MAXC - 8) begin
                if (vpat[t]) begin seen++; idle = 0; end
                else idle++;
                if (t == ab_at) begin ab = 1; stop = 1; end
                else if (vpat[t] && seen == int'(words)) fin = 1;
                else if (TO_EN && idle == TO) begin to = 1; stop = 1; end
                t++;
            end
        end
        for (int i = 0; i < 2 && !stop; i++) begin
            if (t == ab_at) begin ab = 1; stop = 1; end
            t++;
        end
        rep_t = t;
        exp_pass = (errs == 0) && !ab && !to && (seen == int'(words));
        if (restart_at > rep_t) restart_at = -1;

        @(negedge clk);
        bus.cfg_mode = mode; bus.cfg_throttle = thr; bus.cfg_words = words;
        bus.chk_error_count = errs; bus.start = 1'b1; bus.abort = 1'b0; bus.chk_valid = vpat[0];
        @(negedge clk);
        bus.start = 1'b0;
        bus.cfg_mode = ~mode; bus.cfg_throttle = $urandom; bus.cfg_words = $urandom;
        rc_o = 0; ts_o = 0; busy_o = 0; done_n = 0; done_k = -1; cfg_bad = 0;
        for (int k = 1; k <= rep_t + 3; k++) begin
            rc_o += int'(bus.chk_reset);
            ts_o += int'(bus.throttle_set);
            busy_o += int'(bus.busy);
            if (bus.done) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            if (bus.chk_mode !== mode || bus.throttle_val !== thr) cfg_bad = 1;
            bus.chk_valid = vpat[k];
            bus.abort = (k == ab_at);
            bus.start = (k == restart_at);
            @(negedge clk);
        end
        bus.chk_valid = 1'b0; bus.abort = 1'b0; bus.start = 1'b0;

        n_tests++; if (rc_o !== rc_m) begin n_fail++; $display("FAIL %s chk_reset_cycles: got %0d exp %0d", name, rc_o, rc_m); end
        n_tests++; if (ts_o !== ts_m) begin n_fail++; $display("FAIL %s throttle_set_pulses: got %0d exp %0d", name, ts_o, ts_m); end
        n_tests++; if (busy_o !== rep_t) begin n_fail++; $display("FAIL %s busy_cycles: got %0d exp %0d", name, busy_o, rep_t); end
        n_tests++; if (done_n !== 1) begin n_fail++; $display("FAIL %s done_pulses: got %0d exp 1", name, done_n); end
        n_tests++; if (done_k !== rep_t + 1) begin n_fail++; $display("FAIL %s done_cycle: got %0d exp %0d", name, done_k, rep_t + 1); end
        n_tests++; if (bus.words_seen !== 32'(seen)) begin n_fail++; $display("FAIL %s words_seen: got %0d exp %0d", name, bus.words_seen, seen); end
        n_tests++; if (bus.aborted !== ab) begin n_fail++; $display("FAIL %s aborted: got %0b exp %0b", name, bus.aborted, ab); end
        n_tests++; if (bus.timed_out !== to) begin n_fail++; $display("FAIL %s timed_out: got %0b exp %0b", name, bus.timed_out, to); end
        n_tests++; if (bus.pass !== exp_pass) begin n_fail++; $display("FAIL %s pass: got %0b exp %0b", name, bus.pass, exp_pass); end
        n_tests++; if (bus.result_errors !== errs) begin n_fail++; $display("FAIL %s result_errors: got %0d exp %0d", name, bus.result_errors, errs); end
        n_tests++; if (cfg_bad) begin n_fail++; $display("FAIL %s cfg_stable: got unstable exp mode=%0b thr=%0h", name, mode, thr); end
        n_tests++; if (bus.chk_mode !== mode || bus.throttle_val !== thr) begin
            n_fail++; $display("FAIL %s cfg_hold: got %0b/%0h exp %0b/%0h", name, bus.chk_mode, bus.throttle_val, mode, thr);
        end
    endtask

    task automatic test_reset();
        bus.start = 0; bus.abort = 0; bus.cfg_mode = 0; bus.cfg_throttle = 0; bus.cfg_words = 0;
        bus.chk_valid = 0; bus.chk_error_count = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (bus.chk_reset !== 1'b1) begin n_fail++; $display("FAIL reset chk_reset_high: got %0b exp 1", bus.chk_reset); end
        reset = 1'b0;
        @(negedge clk);
        n_tests++; if ({bus.busy, bus.done, bus.pass, bus.aborted, bus.timed_out, bus.throttle_set, bus.chk_reset, bus.chk_mode} !== 8'b0) begin
            n_fail++; $display("FAIL reset flags: got %08b exp 00000000", {bus.busy, bus.done, bus.pass, bus.aborted, bus.timed_out, bus.throttle_set, bus.chk_reset, bus.chk_mode});
        end
        n_tests++; if ({bus.words_seen, bus.result_errors, bus.throttle_val} !== 96'b0) begin
            n_fail++; $display("FAIL reset counters: got %0d/%0d/%0h exp 0/0/0", bus.words_seen, bus.result_errors, bus.throttle_val);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < MAXC; i++) vpat[i] = 1'b1;
        scenario("basic", 32'd16, 32'd0, 1'b1, 32'hFFFF_FFFF, -1, -1);
    endtask

    task automatic test_errors();
        fill_random(60);
        scenario("errors", 32'd8, 32'd3, 1'b0, 32'h1234_5678, -1, -1);
    endtask

    task automatic test_zero_words();
        fill_random(50);
        scenario("zero_words", 32'd0, 32'd0, 1'b1, 32'h0000_00F0, -1, -1);
    endtask

    task automatic test_abort_last();
        int t, n;
        fill_random(60);
        t = R + 2; n = 0;
        while (t < MAXC - 16) begin
            if (vpat[t]) n++;
            if (n == 5) break;
            t++;
        end
        scenario("abort_last", 32'd5, 32'd0, 1'b1, 32'hA5A5_A5A5, t, -1);
    endtask

    task automatic test_abort_phases();
        fill_random(50);
        scenario("abort_reset", 32'd6, 32'd0, 1'b0, 32'h1, 2, -1);
        scenario("abort_load", 32'd6, 32'd0, 1'b1, 32'h2, R + 1, -1);
        for (int i = 0; i < MAXC; i++) vpat[i] = 1'b1;
        scenario("abort_drain", 32'd2, 32'd0, 1'b0, 32'h3, R + 5, -1);
    endtask

    task automatic test_timeout();
        int rs;
        rs = R + 2;
        fill_random(50);
        for (int i = rs; i < MAXC; i++) vpat[i] = 1'b0;
        vpat[rs] = 1'b1; vpat[rs + 2] = 1'b1; vpat[rs + 5] = 1'b1;
`ifdef PIPE_TEST_TIMEOUT_EN
        scenario("timeout", 32'd10, 32'd0, 1'b1, 32'h55, -1, -1);
`else
        scenario("no_timeout", 32'd10, 32'd0, 1'b1, 32'h55, rs + 5 + 300, -1);
`endif
    endtask

    task automatic test_restart();
        fill_random(70);
        scenario("restart", 32'd12, 32'd0, 1'b0, 32'hDEAD_BEEF, -1, R + 4);
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        done_seen = 0;
        @(negedge clk);
        bus.cfg_mode = 1'b1; bus.cfg_throttle = 32'hCAFE; bus.cfg_words = 32'd50;
        bus.chk_error_count = 0; bus.chk_valid = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (R + 4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.chk_reset !== 1'b1) begin n_fail++; $display("FAIL mid_reset chk_reset_high: got %0b exp 1", bus.chk_reset); end
        if (bus.done) done_seen++;
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        n_tests++; if (done_seen !== 0) begin n_fail++; $display("FAIL mid_reset done_pulses: got %0d exp 0", done_seen); end
        n_tests++; if ({bus.busy, bus.done, bus.pass, bus.aborted, bus.timed_out, bus.throttle_set, bus.chk_reset, bus.chk_mode} !== 8'b0) begin
            n_fail++; $display("FAIL mid_reset flags: got %08b exp 00000000", {bus.busy, bus.done, bus.pass, bus.aborted, bus.timed_out, bus.throttle_set, bus.chk_reset, bus.chk_mode});
        end
        n_tests++; if ({bus.words_seen, bus.result_errors, bus.throttle_val} !== 96'b0) begin
            n_fail++; $display("FAIL mid_reset counters: got %0d/%0d/%0h exp 0/0/0", bus.words_seen, bus.result_errors, bus.throttle_val);
        end
        bus.chk_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] words, errs;
        int ab_at, rs_at;
        for (int n = 0; n < 25; n++) begin
            fill_random(int'($urandom_range(40, 90)));
            words = $urandom_range(0, 20);
            errs = ($urandom_range(1) == 0) ? 32'd0 : 32'($urandom_range(1, 7));
            ab_at = ($urandom_range(3) == 0) ? int'($urandom_range(1, R + 8 + 2 * int'(words))) : -1;
            rs_at = ($urandom_range(1) == 0) ? int'($urandom_range(1, R + 3)) : -1;
            scenario("random", words, errs, 1'($urandom_range(1)), $urandom, ab_at, rs_at);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_zero_words();
        test_abort_last();
        test_abort_phases();
        test_timeout();
        test_restart();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
